// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: opcodes, IR field
// positions, FSM state encoding and small decode helpers.
package instr_sequencer_pkg;

  // Opcodes the sequencer treats specially; all others are plain ALU ops.
  localparam logic [4:0] OP_MUL  = 5'b01100;
  localparam logic [4:0] OP_DIV  = 5'b01101;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // IR field bit positions.
  localparam int OP_HI = 31;
  localparam int OP_LO = 27;
  localparam int WR_HI = 26;
  localparam int WR_LO = 23;
  localparam int RA_HI = 22;
  localparam int RA_LO = 19;
  localparam int RB_HI = 18;
  localparam int RB_LO = 15;

  // Wait counter width; holds the largest legal timeout (255).
  localparam int TIMER_W = 8;

  // FSM encoding, kept as plain constants for compatibility with older tools.
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_FETCH  = 3'd1;
  localparam state_t S_DECODE = 3'd2;
  localparam state_t S_EXEC   = 3'd3;
  localparam state_t S_WAIT   = 3'd4;
  localparam state_t S_WB     = 3'd5;
  localparam state_t S_HALT   = 3'd6;

  // Multi-cycle ops wait for alu_done and write HI/LO instead of a GPR.
  function automatic logic is_muldiv(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/instr_sequencer_wait_timer.sv
// Wait-state timer for mul/div: cleared on launch, counts each WAIT cycle
// without alu_done and flags the cycle in which it reaches the timeout.
module seq_wait_timer
  import instr_sequencer_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic clr,
  input  logic clear,
  input  logic en,
  output logic tc
);

  logic [TIMER_W-1:0] count;

  // Terminal count: this enabled cycle is the TIMEOUT-th one.
  assign tc = en && (count == TIMER_W'(TIMEOUT - 1));

  // Counter with synchronous clear, saturating so it can never wrap back.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && (count != {TIMER_W{1'b1}})) begin
      count <= count + TIMER_W'(1);
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle control FSM for the register-file/ALU datapath: fetches over a
// req/ack port, decodes the IR into selects, launches the ALU, waits on
// mul/div and issues GPR or HI/LO writeback strobes.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int ADDR_W         = 9,
  parameter int PC_RESET       = 0,
  parameter int MULDIV_TIMEOUT = 64,
  parameter int RETIRE_W       = 16
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                run,
  output logic                mem_req,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic                mem_ack,
  input  logic [31:0]         mem_rdata,
  output logic [31:0]         ir,
  output logic [3:0]          rf_rd_a_sel,
  output logic [3:0]          rf_rd_b_sel,
  output logic [3:0]          rf_wr_sel,
  output logic                rf_wr_en,
  output logic [4:0]          alu_op,
  output logic                alu_start,
  input  logic                alu_done,
  output logic                hilo_wr_en,
  output logic                busy,
  output logic                halted,
  output logic                timeout_err,
  output logic [RETIRE_W-1:0] retired
);

  localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(PC_RESET);

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] pc;
  logic [4:0]        opcode;
  logic              muldiv;
  logic              retire;
  logic              timer_tc;

  assign opcode = ir[OP_HI:OP_LO];
  assign muldiv = is_muldiv(opcode);

  // Everything below derives from state/IR only, so clr forces all strobes
  // low immediately without waiting for a clock.
  assign mem_req     = (state == S_FETCH);
  assign mem_addr    = pc;
  assign rf_rd_a_sel = ir[RA_HI:RA_LO];
  assign rf_rd_b_sel = ir[RB_HI:RB_LO];
  assign rf_wr_sel   = ir[WR_HI:WR_LO];
  assign alu_op      = opcode;
  assign alu_start   = (state == S_EXEC);
  assign rf_wr_en    = (state == S_WB) && !muldiv && (rf_wr_sel != 4'd0);
  assign hilo_wr_en  = (state == S_WB) && muldiv;
  assign busy        = (state != S_IDLE) && (state != S_HALT);
  assign halted      = (state == S_HALT);

  // NOPs retire straight out of DECODE; everything else retires in WB.
  assign retire = ((state == S_DECODE) && (opcode == OP_NOP)) || (state == S_WB);

  seq_wait_timer #(
    .TIMEOUT(MULDIV_TIMEOUT)
  ) u_wait_timer (
    .clk  (clk),
    .clr  (clr),
    .clear(state == S_EXEC),
    .en   ((state == S_WAIT) && !alu_done),
    .tc   (timer_tc)
  );

  // Next-state decode.
  always_comb begin
    // NOTE: default first so no path through the case leaves state_nx unassigned (no latch).
    state_nx = state;
    case (state)
      S_IDLE:   if (run) state_nx = S_FETCH;
      S_FETCH:  if (mem_ack) state_nx = S_DECODE;
      S_DECODE: begin
        if (opcode == OP_HALT)     state_nx = S_HALT;
        else if (opcode == OP_NOP) state_nx = run ? S_FETCH : S_IDLE;
        else                       state_nx = S_EXEC;
      end
      S_EXEC:   state_nx = muldiv ? S_WAIT : S_WB;
      // alu_done is checked first so it wins over a simultaneous timeout.
      S_WAIT: begin
        if (alu_done)      state_nx = S_WB;
        else if (timer_tc) state_nx = S_HALT;
      end
      S_WB:     state_nx = run ? S_FETCH : S_IDLE;
      S_HALT:   state_nx = S_HALT;
      default:  state_nx = S_IDLE;
    endcase
  end

  // State, PC, IR, sticky timeout flag and retire counter.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state       <= S_IDLE;
      pc          <= PC_INIT;
      ir          <= '0;
      timeout_err <= 1'b0;
      retired     <= '0;
    end else begin
      // NOTE: non-blocking so every register here sees the pre-edge values.
      state <= state_nx;
      if ((state == S_FETCH) && mem_ack) begin
        ir <= mem_rdata;
        pc <= pc + ADDR_W'(1);
      end
      if ((state == S_WAIT) && timer_tc) timeout_err <= 1'b1;
      if (retire) retired <= retired + RETIRE_W'(1);
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: table of single-instruction
// programs plus hand-written multi-cycle sequences. Small configuration
// (ADDR_W=2, MULDIV_TIMEOUT=8) so PC wrap and timeout are quick to reach.
module tb_instr_sequencer;
  import instr_sequencer_pkg::*;

  localparam int ADDR_W  = 2;
  localparam int TMO     = 8;
  localparam int RET_W   = 16;

  logic              clk;
  logic              clr;
  logic              run;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [31:0]       mem_rdata;
  logic [31:0]       ir;
  logic [3:0]        rf_rd_a_sel, rf_rd_b_sel, rf_wr_sel;
  logic              rf_wr_en;
  logic [4:0]        alu_op;
  logic              alu_start;
  logic              alu_done;
  logic              hilo_wr_en;
  logic              busy, halted, timeout_err;
  logic [RET_W-1:0]  retired;

  logic [31:0] mem [4];
  int ack_delay;
  int done_delay;
  int n_checks;
  int n_fail;

  // Event counters, cleared by clr.
  int         n_rf, n_hilo, n_start, n_req, fetch_n;
  logic [3:0] cap_a, cap_b, last_wr_sel;
  logic [4:0] cap_op;
  logic [ADDR_W-1:0] fetch_log [16];

  instr_sequencer #(
    .ADDR_W(ADDR_W), .PC_RESET(0), .MULDIV_TIMEOUT(TMO), .RETIRE_W(RET_W)
  ) dut (
    .clk(clk), .clr(clr), .run(run),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ir(ir), .rf_rd_a_sel(rf_rd_a_sel), .rf_rd_b_sel(rf_rd_b_sel), .rf_wr_sel(rf_wr_sel),
    .rf_wr_en(rf_wr_en), .alu_op(alu_op), .alu_start(alu_start), .alu_done(alu_done),
    .hilo_wr_en(hilo_wr_en), .busy(busy), .halted(halted), .timeout_err(timeout_err),
    .retired(retired)
  );

  assign mem_rdata = mem[mem_addr];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory and ALU responders, updated away from the active edge.
  initial begin
    int ack_cnt;
    int dcnt;
    ack_cnt  = 0;
    dcnt     = 1000;
    mem_ack  = 1'b0;
    alu_done = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        mem_ack = (ack_cnt >= ack_delay);
        ack_cnt++;
      end else begin
        mem_ack = 1'b0;
        ack_cnt = 0;
      end
      if (alu_start)       dcnt = 0;
      else if (dcnt < 1000) dcnt++;
      alu_done = (done_delay >= 0) && (dcnt == done_delay);
    end
  end

  // Strobe and fetch logging.
  always @(posedge clk or posedge clr) begin
    if (clr) begin
      n_rf <= 0; n_hilo <= 0; n_start <= 0; n_req <= 0; fetch_n <= 0;
      cap_a <= '0; cap_b <= '0; cap_op <= '0; last_wr_sel <= '0;
    end else begin
      if (rf_wr_en) begin
        n_rf        <= n_rf + 1;
        last_wr_sel <= rf_wr_sel;
      end
      if (hilo_wr_en) n_hilo <= n_hilo + 1;
      if (alu_start) begin
        n_start <= n_start + 1;
        cap_a   <= rf_rd_a_sel;
        cap_b   <= rf_rd_b_sel;
        cap_op  <= alu_op;
      end
      if (mem_req) n_req <= n_req + 1;
      if (mem_req && mem_ack && (fetch_n < 16)) begin
        fetch_log[fetch_n] <= mem_addr;
        fetch_n            <= fetch_n + 1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [3:0] d, a, b);
    return {op, d, a, b, 15'h0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    run        = 1'b0;
    ack_delay  = 0;
    done_delay = -1;
    for (int i = 0; i < 4; i++) mem[i] = mk(OP_HALT, 4'd0, 4'd0, 4'd0);
    clr = 1'b1;
    @(negedge clk);
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic wait_halted(input int budget, input string name);
    for (int i = 0; i < budget && !halted; i++) @(negedge clk);
    check(name, halted, 1);
  endtask

  task automatic wait_start(input int budget, input string name);
    for (int i = 0; i < budget && !alu_start; i++) @(negedge clk);
    check(name, alu_start, 1);
  endtask

  typedef struct {
    logic [31:0] instr;
    int          done_delay;
    int          exp_rf;
    int          exp_hilo;
    int          exp_start;
    int          exp_ret;
    logic [3:0]  exp_a;
    logic [3:0]  exp_b;
    logic [3:0]  exp_wr;
    logic [4:0]  exp_op;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int cyc;
    int bad;
    n_checks = 0;
    n_fail   = 0;
    clr      = 1'b1;
    run      = 1'b0;
    ack_delay  = 0;
    done_delay = -1;

    vecs[0] = '{mk(5'b00011, 4'd3,  4'd1,  4'd2),  -1, 1, 0, 1, 1, 4'd1,  4'd2,  4'd3,  5'b00011};
    vecs[1] = '{mk(5'b00101, 4'd15, 4'd15, 4'd0),  -1, 1, 0, 1, 1, 4'd15, 4'd0,  4'd15, 5'b00101};
    vecs[2] = '{mk(5'b00000, 4'd0,  4'd7,  4'd9),  -1, 0, 0, 1, 1, 4'd7,  4'd9,  4'd0,  5'b00000};
    vecs[3] = '{mk(5'b11010, 4'd5,  4'd1,  4'd1),  -1, 0, 0, 0, 1, 4'd0,  4'd0,  4'd0,  5'b00000};
    vecs[4] = '{mk(5'b01100, 4'd4,  4'd2,  4'd3),   6, 0, 1, 1, 1, 4'd2,  4'd3,  4'd4,  5'b01100};
    vecs[5] = '{mk(5'b01101, 4'd0,  4'd6,  4'd8),   1, 0, 1, 1, 1, 4'd6,  4'd8,  4'd0,  5'b01101};
    vecs[6] = '{mk(5'b00111, 4'd6,  4'd0,  4'd1),   1, 1, 0, 1, 1, 4'd0,  4'd1,  4'd6,  5'b00111};
    vecs[7] = '{mk(5'b11011, 4'd2,  4'd3,  4'd4),  -1, 0, 0, 0, 0, 4'd0,  4'd0,  4'd0,  5'b00000};

    // Reset state.
    do_reset();
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_ir", ir, 0);
    check("rst_busy", busy, 0);
    check("rst_halted", halted, 0);
    check("rst_timeout", timeout_err, 0);
    check("rst_retired", retired, 0);
    check("rst_alu_start", alu_start, 0);
    check("rst_rf_wr_en", rf_wr_en, 0);
    check("rst_hilo", hilo_wr_en, 0);

    // Table: one instruction followed by HALT.
    for (int k = 0; k < 8; k++) begin
      do_reset();
      mem[0]     = vecs[k].instr;
      done_delay = vecs[k].done_delay;
      run        = 1'b1;
      wait_halted(60, $sformatf("v%0d_halted", k));
      check($sformatf("v%0d_rf_wr_cnt", k), n_rf, vecs[k].exp_rf);
      check($sformatf("v%0d_hilo_cnt", k), n_hilo, vecs[k].exp_hilo);
      check($sformatf("v%0d_start_cnt", k), n_start, vecs[k].exp_start);
      check($sformatf("v%0d_retired", k), retired, vecs[k].exp_ret);
      check($sformatf("v%0d_timeout", k), timeout_err, 0);
      if (vecs[k].exp_start > 0) begin
        check($sformatf("v%0d_sel_a", k), cap_a, vecs[k].exp_a);
        check($sformatf("v%0d_sel_b", k), cap_b, vecs[k].exp_b);
        check($sformatf("v%0d_alu_op", k), cap_op, vecs[k].exp_op);
      end
      if (vecs[k].exp_rf > 0) check($sformatf("v%0d_wr_sel", k), last_wr_sel, vecs[k].exp_wr);
    end

    // Cycle-by-cycle ALU op with zero-wait memory.
    do_reset();
    mem[0] = mk(5'b00011, 4'd3, 4'd1, 4'd2);
    run = 1'b1;
    @(negedge clk);
    check("t1_c1_req", mem_req, 1);
    check("t1_c1_addr", mem_addr, 0);
    @(negedge clk);
    check("t1_c2_sel_a", rf_rd_a_sel, 1);
    check("t1_c2_sel_b", rf_rd_b_sel, 2);
    check("t1_c2_start", alu_start, 0);
    @(negedge clk);
    check("t1_c3_start", alu_start, 1);
    check("t1_c3_op", alu_op, 5'b00011);
    @(negedge clk);
    check("t1_c4_rf_wr_en", rf_wr_en, 1);
    check("t1_c4_wr_sel", rf_wr_sel, 3);
    check("t1_c4_start", alu_start, 0);
    @(negedge clk);
    check("t1_c5_retired", retired, 1);
    check("t1_c5_pc", mem_addr, 1);
    check("t1_c5_req", mem_req, 1);

    // Div timeout after exactly TMO wait cycles.
    do_reset();
    mem[0] = mk(OP_DIV, 4'd2, 4'd3, 4'd4);
    run = 1'b1;
    wait_start(20, "to_start_seen");
    cyc = 0;
    while (!halted && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("to_cycles_to_halt", cyc, TMO + 1);
    check("to_timeout_err", timeout_err, 1);
    check("to_halted", halted, 1);
    check("to_busy", busy, 0);
    check("to_hilo_cnt", n_hilo, 0);
    check("to_retired", retired, 0);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (!halted || busy || mem_req || !timeout_err) bad++;
    end
    check("to_stays_halted", bad, 0);

    // alu_done in the same cycle the timeout would fire: done wins.
    do_reset();
    mem[0]     = mk(OP_MUL, 4'd1, 4'd2, 4'd3);
    done_delay = TMO;
    run        = 1'b1;
    wait_halted(60, "race_halted");
    check("race_timeout", timeout_err, 0);
    check("race_hilo_cnt", n_hilo, 1);
    check("race_retired", retired, 1);

    // Dest-0 ALU op, NOP, HALT.
    do_reset();
    mem[0] = mk(5'b00010, 4'd0, 4'd5, 4'd6);
    mem[1] = mk(OP_NOP, 4'd0, 4'd0, 4'd0);
    run = 1'b1;
    wait_halted(60, "seq_halted");
    check("seq_rf_wr_cnt", n_rf, 0);
    check("seq_retired", retired, 2);
    check("seq_start_cnt", n_start, 1);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (mem_req) bad++;
    end
    check("seq_no_req_after_halt", bad, 0);

    // Slow memory, run dropped during EXEC.
    do_reset();
    mem[0]    = mk(5'b00100, 4'd5, 4'd1, 4'd1);
    ack_delay = 3;
    run       = 1'b1;
    wait_start(30, "slow_start_seen");
    run = 1'b0;
    for (int i = 0; i < 10 && busy; i++) @(negedge clk);
    check("slow_busy", busy, 0);
    check("slow_halted", halted, 0);
    check("slow_req_cycles", n_req, 4);
    check("slow_rf_wr_cnt", n_rf, 1);
    check("slow_wr_sel", last_wr_sel, 5);
    check("slow_retired", retired, 1);
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (mem_req || busy) bad++;
    end
    check("slow_stays_idle", bad, 0);
    check("slow_pc", mem_addr, 1);

    // Asynchronous clr while waiting on a mul.
    do_reset();
    mem[0] = mk(5'b00001, 4'd1, 4'd2, 4'd3);
    mem[1] = mk(OP_MUL, 4'd7, 4'd1, 4'd2);
    run = 1'b1;
    for (int i = 0; i < 20 && retired != 1; i++) @(negedge clk);
    check("clr_pre_retired", retired, 1);
    wait_start(20, "clr_mul_start");
    @(negedge clk);
    @(negedge clk);
    check("clr_pre_busy", busy, 1);
    #1 clr = 1'b1;
    #1;
    check("clr_mem_req", mem_req, 0);
    check("clr_pc", mem_addr, 0);
    check("clr_ir", ir, 0);
    check("clr_busy", busy, 0);
    check("clr_halted", halted, 0);
    check("clr_retired", retired, 0);
    check("clr_alu_op", alu_op, 0);
    check("clr_wr_sel", rf_wr_sel, 0);
    check("clr_strobes", {alu_start, rf_wr_en, hilo_wr_en, timeout_err}, 0);
    @(negedge clk);
    clr = 1'b0;
    run = 1'b0;

    // PC wrap across NOPs with a 2-bit address.
    do_reset();
    for (int i = 0; i < 4; i++) mem[i] = mk(OP_NOP, 4'd0, 4'd0, 4'd0);
    run = 1'b1;
    for (int i = 0; i < 40 && retired < 5; i++) @(negedge clk);
    check("wrap_retired5", retired, 5);
    run = 1'b0;
    for (int i = 0; i < 10 && busy; i++) @(negedge clk);
    check("wrap_fetch_cnt", fetch_n, 6);
    for (int i = 0; i < 5; i++) check($sformatf("wrap_addr%0d", i), fetch_log[i], i % 4);
    check("wrap_final_retired", retired, 6);
    check("wrap_final_pc", mem_addr, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
